// File: rtl/bcd2_seg7_scan.sv
// -----------------------------------------------------------------------------
// bcd2_seg7_scan
//   Two-digit common-anode multiplexed 7-segment driver for a 0..99 BCD count.
//   The display scans BLANK_T -> SHOW_T -> BLANK_U -> SHOW_U. All anodes are
//   dark during each BLANK_* phase, which removes ghosting at digit switches.
//   Both digits are captured together once per frame, on entry to SHOW_T, so
//   the tens and units digits on the display always belong to the same count.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined     : a tens digit of 0 is left dark during SHOW_T (timing unchanged)
//     not defined : the tens digit is always driven, so 0 shows as '0'
//
//   All outputs are flops. They are loaded from the next-state view of the
//   FSM, so they change on the same edge as the state they belong to.
// -----------------------------------------------------------------------------
module bcd2_seg7_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dig_tens,
    input  logic [3:0] dig_units,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    // Counter must reach the larger of the two phase lengths minus one.
    localparam int MAX_LIM = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LIM + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_UNITS = 2'b10;

    typedef enum logic [1:0] {
        ST_BLANK_T = 2'd0,
        ST_SHOW_T  = 2'd1,
        ST_BLANK_U = 2'd2,
        ST_SHOW_U  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] last_s;
    logic [3:0]       tens_r;
    logic [3:0]       units_r;
    logic [3:0]       tens_nxt_s;
    logic [3:0]       units_nxt_s;
    logic             snapshot_s;
    logic [6:0]       seg_nxt_s;
    logic [1:0]       an_nxt_s;
    logic             tick_nxt_s;

    // BCD digit to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // State, phase counter and digit snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_BLANK_T;
            cnt_r   <= CNT_ZERO;
            tens_r  <= 4'd0;
            units_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            tens_r  <= tens_nxt_s;
            units_r <= units_nxt_s;
        end
    end

    // Next-state: advance the phase when the counter reaches its last value.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        last_s      = BLANK_LAST;
        case (state_r)
            ST_SHOW_T: last_s = SHOW_LAST;
            ST_SHOW_U: last_s = SHOW_LAST;
            default:   last_s = BLANK_LAST;
        endcase

        if (cnt_r == last_s) begin
            cnt_nxt_s = CNT_ZERO;
            case (state_r)
                ST_BLANK_T: state_nxt_s = ST_SHOW_T;
                ST_SHOW_T:  state_nxt_s = ST_BLANK_U;
                ST_BLANK_U: state_nxt_s = ST_SHOW_U;
                ST_SHOW_U:  state_nxt_s = ST_BLANK_T;
                default:    state_nxt_s = ST_BLANK_T;
            endcase
        end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            state_nxt_s = state_r;
        end
    end

    // Snapshot both digits together on the BLANK_T -> SHOW_T transition only.
    always_comb begin
        snapshot_s = (state_r == ST_BLANK_T) && (cnt_r == BLANK_LAST);
        if (snapshot_s) begin
            tens_nxt_s  = dig_tens;
            units_nxt_s = dig_units;
        end else begin
            tens_nxt_s  = tens_r;
            units_nxt_s = units_r;
        end
    end

    // Output decode from the upcoming state so registered outputs track it.
    always_comb begin
        seg_nxt_s  = SEG_DARK;
        an_nxt_s   = AN_OFF;
        tick_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_SHOW_T: begin
                tick_nxt_s = snapshot_s;
`ifdef LEADING_ZERO_BLANK_EN
                if (tens_nxt_s == 4'd0) begin
                    an_nxt_s  = AN_OFF;
                    seg_nxt_s = SEG_DARK;
                end else begin
                    an_nxt_s  = AN_TENS;
                    seg_nxt_s = enc7(tens_nxt_s);
                end
`else
                an_nxt_s  = AN_TENS;
                seg_nxt_s = enc7(tens_nxt_s);
`endif
            end
            ST_SHOW_U: begin
                tick_nxt_s = 1'b0;
                an_nxt_s   = AN_UNITS;
                seg_nxt_s  = enc7(units_nxt_s);
            end
            default: begin
                tick_nxt_s = 1'b0;
                an_nxt_s   = AN_OFF;
                seg_nxt_s  = SEG_DARK;
            end
        endcase
    end

    // Output registers; reset leaves the display dark.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= SEG_DARK;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt_s;
            an         <= an_nxt_s;
            frame_tick <= tick_nxt_s;
        end
    end

endmodule

// File: tb/tb_bcd2_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd2_seg7_scan
//   Directed bench for bcd2_seg7_scan with REFRESH_DIV=4, BLANK_CYCLES=2
//   (12-cycle frame). Expected segment codes are written out by hand.
//   Honours LEADING_ZERO_BLANK_EN when choosing the expected tens-zero view.
// -----------------------------------------------------------------------------
module tb_bcd2_seg7_scan;

    logic       clk;
    logic       reset;
    logic [3:0] dig_tens;
    logic [3:0] dig_units;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int err_cnt;
    int chk_cnt;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    // Hand-written active-low codes for digits 0..9.
    logic [6:0] enc_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    bcd2_seg7_scan #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dig_tens   (dig_tens),
        .dig_units  (dig_units),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the three outputs just after the edge.
    task automatic step_chk(input string tag, input logic [1:0] e_an,
                            input logic [6:0] e_seg, input logic e_tick);
        @(posedge clk);
        #1;
        check_eq({tag, ".an"},   {30'd0, an},   {30'd0, e_an});
        check_eq({tag, ".seg"},  {25'd0, seg},  {25'd0, e_seg});
        check_eq({tag, ".tick"}, {31'd0, frame_tick}, {31'd0, e_tick});
    endtask

    // One full frame starting at the BLANK_T -> SHOW_T edge.
    task automatic run_frame(input string tag, input logic [3:0] t_in, input logic [3:0] u_in,
                             input bit do_mid, input logic [3:0] mid_t,
                             input logic [1:0] e_t_an, input logic [6:0] e_t_seg,
                             input logic [6:0] e_u_seg);
        dig_tens  = t_in;
        dig_units = u_in;
        for (int i = 0; i < 4; i++) begin
            step_chk({tag, ".show_t"}, e_t_an, e_t_seg, (i == 0));
            if (i == 0 && do_mid) dig_tens = mid_t;
        end
        for (int i = 0; i < 2; i++) step_chk({tag, ".blank_u"}, 2'b11, 7'h7F, 1'b0);
        for (int i = 0; i < 4; i++) step_chk({tag, ".show_u"}, 2'b10, e_u_seg, 1'b0);
        for (int i = 0; i < 2; i++) step_chk({tag, ".blank_t"}, 2'b11, 7'h7F, 1'b0);
    endtask

    initial begin
        int n;
        logic [1:0] t_an;
        logic [6:0] t_seg;
        err_cnt   = 0;
        chk_cnt   = 0;
        reset     = 1'b0;
        dig_tens  = 4'd4;
        dig_units = 4'd2;

        // Test 1: reset state, then first frame after release.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.an",   {30'd0, an},   32'h3);
        check_eq("rst.seg",  {25'd0, seg},  32'h7F);
        check_eq("rst.tick", {31'd0, frame_tick}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step_chk("t1.blank0", 2'b11, 7'h7F, 1'b0);
        run_frame("t1", 4'd4, 4'd2, 1'b0, 4'd0, 2'b01, 7'b0011001, 7'b0100100);

        // Test 2: sweep all BCD digits on both positions.
        for (int i = 0; i < 10; i++) begin
            if (i == 0 && LZ) begin
                t_an  = 2'b11;
                t_seg = 7'h7F;
            end else begin
                t_an  = 2'b01;
                t_seg = enc_tab[i];
            end
            run_frame("t2", 4'(i), 4'(9 - i), 1'b0, 4'd0, t_an, t_seg, enc_tab[9 - i]);
        end

        // Test 3: tens change during SHOW_T is held off until the next frame.
        run_frame("t3a", 4'd4, 4'd2, 1'b1, 4'd7, 2'b01, 7'b0011001, 7'b0100100);
        run_frame("t3b", 4'd7, 4'd2, 1'b0, 4'd0, 2'b01, 7'b1111000, 7'b0100100);

        // Test 4: non-BCD codes show a dash.
        run_frame("t4", 4'hC, 4'hF, 1'b0, 4'd0, 2'b01, 7'b0111111, 7'b0111111);

        // Test 5: leading zero handling.
        if (LZ) run_frame("t5", 4'd0, 4'd7, 1'b0, 4'd0, 2'b11, 7'h7F, 7'b1111000);
        else    run_frame("t5", 4'd0, 4'd7, 1'b0, 4'd0, 2'b01, 7'b1000000, 7'b1111000);

        // Test 6: reset asserted during SHOW_U.
        dig_tens  = 4'd5;
        dig_units = 4'd3;
        for (int i = 0; i < 4; i++) step_chk("t6.show_t", 2'b01, 7'b0010010, (i == 0));
        for (int i = 0; i < 2; i++) step_chk("t6.blank_u", 2'b11, 7'h7F, 1'b0);
        for (int i = 0; i < 2; i++) step_chk("t6.show_u", 2'b10, 7'b0110000, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6.rst.an",   {30'd0, an},   32'h3);
        check_eq("t6.rst.seg",  {25'd0, seg},  32'h7F);
        check_eq("t6.rst.tick", {31'd0, frame_tick}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step_chk("t6.blank0", 2'b11, 7'h7F, 1'b0);
        run_frame("t6", 4'd4, 4'd2, 1'b0, 4'd0, 2'b01, 7'b0011001, 7'b0100100);

        // Tick period after recovery, with bounded waits.
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_tick && n < 20);
        check_eq("t6.tick_seen", {31'd0, frame_tick}, 32'h1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_tick && n < 30);
        check_eq("t6.tick_period", n, 32'd12);
        @(posedge clk);
        #1;
        check_eq("t6.tick_width", {31'd0, frame_tick}, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
